// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: synchronizes and debounces the tank/climate sensors and
// drives the inlet, sprinkler and drip valves through a small run-time FSM.
module irrigation_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_ON_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       high,
    input  logic       middle,
    input  logic       low,
    input  logic       umidadeDoSolo,
    input  logic       umidadeDoAr,
    input  logic       temperatura,
    output logic       ValvulaDeEntrada,
    output logic       ValvulaDeAspersao,
    output logic       ValvulaDeGotejamento,
    output logic       saidaDoAlarme,
    output logic       erro,
    output logic [2:0] estado
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] ASPERSAO    = 3'd1;
    localparam logic [2:0] GOTEJAMENTO = 3'd2;
    localparam logic [2:0] TROCA       = 3'd3;
    localparam logic [2:0] ALARME      = 3'd4;

    localparam logic [7:0]  db_last  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] run_load = 16'(MIN_ON_CYCLES - 1);
    // Bit order {high, middle, low, solo, ar, temperatura}: soil and air start "wet/humid".
    localparam logic [5:0]  filt_rst = 6'b000110;

    logic [5:0]      raw, sync1_q, sync2_q, filt_q, filt_d;
    logic [5:0][7:0] db_cnt_q, db_cnt_d;
    logic [2:0]      state_q, state_d;
    logic [15:0]     run_q, run_d;
    logic            entrada_d;
    logic            f_high, f_middle, f_low, f_solo, f_ar, f_temp;
    logic            erro_c, alarm_c, demand, sprinkle;

    assign raw = {high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura};
    assign {f_high, f_middle, f_low, f_solo, f_ar, f_temp} = filt_q;

    assign erro_c   = (f_high & ~f_middle) | (f_middle & ~f_low) | (f_high & ~f_low);
    assign alarm_c  = ~f_low | erro_c;
    assign demand   = ~f_solo & ~alarm_c;
    assign sprinkle = f_middle & (~f_ar | f_temp);

    // Debounce: adopt the synchronized value after DEBOUNCE_CYCLES consecutive differences.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == db_last) begin
                    filt_d[i]   = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // FSM next state and minimum-run counter; alarm overrides everything.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (alarm_c) begin
            state_d = ALARME;
        end else begin
            case (state_q)
                IDLE: begin
                    if (demand) begin
                        state_d = sprinkle ? ASPERSAO : GOTEJAMENTO;
                        run_d   = run_load;
                    end
                end
                ASPERSAO, GOTEJAMENTO: begin
                    if (run_q != '0) begin
                        run_d = run_q - 16'd1;
                    end else if (!demand) begin
                        state_d = IDLE;
                    end else if (sprinkle != (state_q == ASPERSAO)) begin
                        state_d = TROCA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Inlet hysteresis; clear wins over set.
    always_comb begin
        entrada_d = ValvulaDeEntrada;
        if (f_high | erro_c) begin
            entrada_d = 1'b0;
        end else if (~f_middle & ~erro_c) begin
            entrada_d = 1'b1;
        end
    end

    // Sensor pipeline state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= filt_rst;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // FSM state and registered outputs; valves decode next state so they align with estado.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            run_q                <= '0;
            ValvulaDeEntrada     <= 1'b0;
            ValvulaDeAspersao    <= 1'b0;
            ValvulaDeGotejamento <= 1'b0;
            saidaDoAlarme        <= 1'b1;
            erro                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            run_q                <= run_d;
            ValvulaDeEntrada     <= entrada_d;
            ValvulaDeAspersao    <= (state_d == ASPERSAO);
            ValvulaDeGotejamento <= (state_d == GOTEJAMENTO);
            saidaDoAlarme        <= alarm_c;
            erro                 <= erro_c;
        end
    end

    assign estado = state_q;

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles needed before a filtered sensor value changes (range 1..255).
REQ-002 The block SHALL have parameter MIN_ON_CYCLES, default 16, giving the minimum cycles an irrigation valve stays open once opened (range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports high, middle, low, input, 1 bit each: tank level probes; 1 = water at that level; asynchronous to clk.
REQ-006 The block SHALL have ports umidadeDoSolo, umidadeDoAr, temperatura, input, 1 bit each: 1 = soil wet, air humid, temperature high; asynchronous to clk.
REQ-007 The block SHALL have port ValvulaDeEntrada, output, 1 bit: tank inlet valve command, registered.
REQ-008 The block SHALL have ports ValvulaDeAspersao and ValvulaDeGotejamento, output, 1 bit each: sprinkler and drip valve commands, registered.
REQ-009 The block SHALL have ports saidaDoAlarme and erro, output, 1 bit each: alarm and probe-inconsistency flags, registered.
REQ-010 The block SHALL have port estado, output, 3 bits: current FSM state code, for the display path.

Function
REQ-011 Each of the six sensor inputs SHALL pass through a 2-flop synchronizer and then a per-input debounce counter.
REQ-012 A filtered value SHALL take the synchronized value on the cycle that value has differed from the filtered value for DEBOUNCE_CYCLES consecutive cycles; any reversion clears that counter.
REQ-013 Filtered values SHALL reset to high=0, middle=0, low=0, umidadeDoSolo=1, umidadeDoAr=1, temperatura=0.
REQ-014 erro SHALL be 1 when filtered (high & ~middle) | (middle & ~low) | (high & ~low) = 1, and 0 otherwise.
REQ-015 saidaDoAlarme SHALL be 1 when filtered low=0 or erro=1.
REQ-016 Irrigation demand SHALL be 1 when filtered umidadeDoSolo=0 and saidaDoAlarme=0.
REQ-017 Mode selection: sprinkler when filtered middle=1 and (umidadeDoAr=0 or temperatura=1); otherwise drip.
REQ-018 FSM states and codes SHALL be IDLE=0, ASPERSAO=1, GOTEJAMENTO=2, TROCA=3, ALARME=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-019 From IDLE with demand=1, the FSM SHALL enter ASPERSAO or GOTEJAMENTO per REQ-017 and load a 16-bit run counter with MIN_ON_CYCLES-1.
REQ-020 In ASPERSAO or GOTEJAMENTO, the run counter SHALL decrement each cycle and saturate at 0.
REQ-021 With counter=0 and demand=0, the FSM SHALL go to IDLE.
REQ-022 With counter=0, demand=1 and mode changed, the FSM SHALL go to TROCA for exactly 1 cycle, with both irrigation valves closed, then go to IDLE.
REQ-023 While counter is nonzero, demand loss and mode changes SHALL be ignored.
REQ-024 From any state, saidaDoAlarme=1 SHALL force ALARME on the next cycle, overriding the minimum run time.
REQ-025 ALARME SHALL exit to IDLE on the first cycle saidaDoAlarme=0.
REQ-026 ValvulaDeAspersao SHALL be 1 only in ASPERSAO; ValvulaDeGotejamento SHALL be 1 only in GOTEJAMENTO; both SHALL never be 1 together.
REQ-027 ValvulaDeEntrada SHALL use hysteresis: set when filtered middle=0 and erro=0; cleared when filtered high=1 or erro=1; otherwise held.
REQ-028 Simultaneous set and clear conditions on ValvulaDeEntrada SHALL resolve as clear.
REQ-029 All outputs SHALL be registered and reflect filtered values and state one cycle after they change.
REQ-030 Latency from a raw input edge to an output change SHALL be 2 + DEBOUNCE_CYCLES + 1 clocks.

Reset
REQ-031 While reset=1, the FSM SHALL be IDLE, estado=0, the run counter 0, all debounce counters and synchronizers 0, and filtered values per REQ-013.
REQ-032 During reset, ValvulaDeEntrada, ValvulaDeAspersao, ValvulaDeGotejamento and erro SHALL be 0, and saidaDoAlarme SHALL be 1, since filtered low=0.
REQ-033 Reset asserted mid-irrigation SHALL close all valves immediately, without waiting for a clock edge.

Verification
REQ-034 Full tank, then set umidadeDoSolo=0, umidadeDoAr=0 -> ValvulaDeAspersao=1 exactly 7 clocks later; drop demand 2 clocks after opening -> valve stays 1 until 16 clocks after opening, then 0.
REQ-035 Set low=1, middle=0, high=1 -> erro=1, saidaDoAlarme=1, estado=4 and all valves 0; restore a consistent level -> estado=0.
REQ-036 While in GOTEJAMENTO with counter=0, set umidadeDoAr=0 -> estado sequence 2,3,0,1 on consecutive cycles, with no cycle where both irrigation valves are 1.
REQ-037 Pulse middle low for 3 cycles (fewer than DEBOUNCE_CYCLES) -> no output change; fill from empty -> ValvulaDeEntrada=1 until high=1 is filtered, then 0.
REQ-038 Assert reset during ASPERSAO between clock edges -> all valves 0 before the next rising edge; deassert -> estado=0.
